// File: rtl/fclass_arbiter.sv
// fclass_arbiter: round-robin sharing of one FCLASS.S classifier among NUM_REQ requesters.
// Define FCLASS_ONEHOT_CHK_EN to flag classifier results that are not exactly one-hot.
module fclass_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [9:0]           rsp_result,
  output logic                 rsp_err,
  output logic                 cls_start,
  output logic [31:0]          cls_fp_in,
  input  logic [9:0]           cls_result,
  input  logic                 cls_done,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam int CW    = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_M1 = TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0;
  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, g;
  logic [31:0]     op_q, op_d;
  logic [9:0]      res_q, res_d;
  logic            err_q, err_d, any, timeout, bad;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Scan downward so the requester closest after rr_q wins.
  always_comb begin
    g = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_valid[(int'(rr_q) + i) % NUM_REQ]) g = ID_W'((int'(rr_q) + i) % NUM_REQ);
  end
  assign any     = |req_valid;
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TO_M1));
`ifdef FCLASS_ONEHOT_CHK_EN
  assign bad = !((cls_result != 10'd0) && ((cls_result & (cls_result - 10'd1)) == 10'd0));
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = ISSUE;
        rr_d    = g;
        id_d    = g;
        op_d    = req_data[32*int'(g) +: 32];
        cnt_d   = '0;
      end
      ISSUE: if (cls_done) begin
        state_d = RESP;
        res_d   = cls_result;
        err_d   = bad;
      end else if (timeout) begin
        state_d = RESP;
        res_d   = '0;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  assign req_ready  = (state_q == IDLE && any) ? NUM_REQ'(1) << g : '0;
  assign rsp_valid  = state_q == RESP;
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign cls_start  = state_q == ISSUE;
  assign cls_fp_in  = op_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_fclass_arbiter.sv
// tb_fclass_arbiter: directed and randomized checks against a transaction-level model.
module tb_fclass_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
`ifdef FCLASS_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*32-1:0] req_data;
  logic [31:0] data [N];
  logic rsp_valid, rsp_err, cls_start, cls_done, busy;
  logic [1:0] rsp_id;
  logic [9:0] rsp_result, cls_result;
  logic [31:0] cls_fp_in;
  bit cls_en = 1'b1, frc_en = 1'b0;
  logic [9:0] frc_val = '0;
  int n_run = 0, n_fail = 0, rr = N - 1;

  fclass_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .cls_start(cls_start), .cls_fp_in(cls_fp_in), .cls_result(cls_result),
    .cls_done(cls_done), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [9:0] fclass(input logic [31:0] x);
    logic s = x[31];
    logic [7:0] e = x[30:23];
    logic [22:0] m = x[22:0];
    int b;
    if (e == 8'hFF) b = (m == 0) ? (s ? 0 : 7) : (m[22] ? 9 : 8);
    else if (e == 8'h00) b = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    else b = s ? 1 : 6;
    return 10'(1 << b);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = data[i];
    cls_done   = cls_en && cls_start;
    cls_result = frc_en ? frc_val : fclass(cls_fp_in);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE: grant, ISSUE, RESP with bp stall cycles, handshake.
  task automatic op(input logic [N-1:0] v, input int bp);
    int g, n;
    logic [9:0] er;
    logic ee;
    req_valid = v;
    #1;
    g = pick(v);
    chk("req_ready_grant", 64'(req_ready), 64'(1 << g));
    chk("busy_idle", 64'(busy), 64'(0));
    er = !cls_en ? 10'd0 : frc_en ? frc_val : fclass(data[g]);
    ee = !cls_en || (CHK && $countones(er) != 1);
    tick();
    rr = g;
    chk("issue_start", 64'(cls_start), 64'(1));
    chk("issue_fp", 64'(cls_fp_in), 64'(data[g]));
    chk("issue_ready", 64'(req_ready), 64'(0));
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("issue_cycles", 64'(n), 64'(cls_en ? 1 : TO));
    for (int b = 0; b <= bp; b++) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rsp_id", 64'(rsp_id), 64'(g));
      chk("rsp_result", 64'(rsp_result), 64'(er));
      chk("rsp_err", 64'(rsp_err), 64'(ee));
      chk("rsp_ready0", 64'({req_ready, cls_start, busy}), 64'({4'b0, 1'b0, 1'b1}));
      if (b == bp) rsp_ready = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    req_valid = '0;
    chk("back_idle", 64'({busy, rsp_valid}), 64'(0));
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    logic [22:0] m;
    int c = $urandom_range(0, 3);
    e = (c == 0) ? 8'h00 : (c == 1) ? 8'hFF : 8'($urandom_range(1, 254));
    m = $urandom_range(0, 2) == 0 ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  initial begin
    for (int i = 0; i < N; i++) data[i] = '0;
    tick();
    chk("reset_outs", 64'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, cls_start, busy}), 64'(0));
    chk("reset_fp", 64'(cls_fp_in), 64'(0));
    rst = 1'b0;
    tick();
    data[0] = 32'h3F800000;
    op(4'b0001, 0);
    chk("t1_result", 64'(fclass(32'h3F800000)), 64'(10'h040));
    data[2] = 32'h40000000;
    req_valid = 4'b0100;
    #1;
    chk("t5_grant", 64'(req_ready), 64'(4'b0100));
    tick();
    rst = 1'b1;
    #1;
    chk("t5_reset", 64'({cls_start, rsp_valid, busy}), 64'(0));
    tick();
    rst = 1'b0;
    rr = N - 1;
    data[0] = 32'hFF800000; data[1] = 32'h00000001; data[2] = 32'h80000000; data[3] = 32'h7FC00000;
    for (int k = 0; k < N; k++) begin
      chk("t2_order", 64'(pick(4'b1111)), 64'(k));
      op(4'b1111, k == 1 ? 5 : 0);
    end
    chk("t2_known", 64'({fclass(data[0]), fclass(data[1]), fclass(data[2]), fclass(data[3])}),
        64'({10'h001, 10'h020, 10'h008, 10'h200}));
    cls_en = 1'b0;
    op(4'b0010, 1);
    cls_en = 1'b1;
    frc_en = 1'b1;
    frc_val = 10'h003;
    op(4'b1000, 0);
    frc_val = 10'h100;
    op(4'b0001, 0);
    frc_en = 1'b0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) data[i] = rnd_fp();
      cls_en = $urandom_range(0, 7) != 0;
      op(4'($urandom_range(1, 15)), $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
